// File: rtl/fetch_queue_unit_if.sv
// Bus bundle for the fetch front end: instruction-memory request/response
// channel and the decode-side valid/ready instruction stream.
interface fetch_queue_unit_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 20
);
    logic                    mem_read;
    logic [ADDRESS_BITS-1:0] mem_address;
    logic                    mem_ready;
    logic                    mem_valid;
    logic [DATA_WIDTH-1:0]   mem_data;
    logic                    inst_valid;
    logic                    inst_ready;
    logic [DATA_WIDTH-1:0]   instruction;
    logic [ADDRESS_BITS-1:0] inst_PC;

    modport master (
        output mem_read, mem_address,
        input  mem_ready, mem_valid, mem_data,
        output inst_valid, instruction, inst_PC,
        input  inst_ready
    );

    modport slave (
        input  mem_read, mem_address,
        output mem_ready, mem_valid, mem_data,
        input  inst_valid, instruction, inst_PC,
        output inst_ready
    );
endinterface

// File: rtl/fetch_queue_unit.sv
// Sequential instruction prefetcher: credit-limited memory reads feed a
// power-of-two FIFO drained by decode; redirects flush and drop stale responses.
module fetch_queue_unit #(
    parameter int CORE            = 0,
    parameter int DATA_WIDTH      = 32,
    parameter int ADDRESS_BITS    = 20,
    parameter int QUEUE_DEPTH     = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic [ADDRESS_BITS-1:0]       program_address,
    input  logic                          redirect,
    input  logic [ADDRESS_BITS-1:0]       redirect_target,
    input  logic                          report,
    output logic [$clog2(QUEUE_DEPTH):0]  queue_count,
    output logic [ADDRESS_BITS-1:0]       fetch_PC,
    fetch_queue_unit_if.master            fq
);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;
    localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [ADDRESS_BITS-1:0] ALIGN_MASK = ~ADDRESS_BITS'(3);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state;
    logic [ADDRESS_BITS-1:0] fetch_pc;
    logic [ADDRESS_BITS-1:0] resp_pc;
    logic [DATA_WIDTH-1:0]   queue_data [QUEUE_DEPTH];
    logic [ADDRESS_BITS-1:0] queue_pc   [QUEUE_DEPTH];
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic [CW-1:0]           count;
    logic [OW-1:0]           outstanding;
    logic [OW-1:0]           drop_count;
    logic [31:0]             enqueued_count;
    logic [31:0]             dropped_count;

    logic                    running;
    logic                    flush;
    logic                    accept;
    logic                    resp;
    logic                    resp_dec;
    logic                    enq;
    logic                    drop;
    logic                    pop;
    logic [31:0]             in_use;
    logic [ADDRESS_BITS-1:0] target_pc;

    assign running   = (state == RUN);
    assign flush     = running && (redirect || start);
    assign target_pc = (redirect ? redirect_target : program_address) & ALIGN_MASK;

    // Entries already queued plus those still owed by memory, minus the ones
    // that will be thrown away, must fit in the queue before asking for more.
    assign in_use      = 32'(count) + 32'(outstanding) - 32'(drop_count);
    assign fq.mem_read = running && !redirect && !start
                         && (32'(outstanding) < 32'(MAX_OUTSTANDING))
                         && (in_use < 32'(QUEUE_DEPTH));
    assign fq.mem_address = fetch_pc >> 2;
    assign accept         = fq.mem_read && fq.mem_ready;

    assign resp     = running && fq.mem_valid;
    assign resp_dec = resp && (outstanding != '0);
    assign enq      = resp && !flush && (drop_count == '0);
    assign drop     = resp && !flush && (drop_count != '0);

    assign fq.inst_valid  = (count != '0);
    assign pop            = fq.inst_valid && fq.inst_ready && !flush;
    assign fq.instruction = queue_data[rd_ptr];
    assign fq.inst_PC     = queue_pc[rd_ptr];

    assign queue_count = count;
    assign fetch_PC    = fetch_pc;

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            fetch_pc       <= '0;
            resp_pc        <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            outstanding    <= '0;
            drop_count     <= '0;
            enqueued_count <= '0;
            dropped_count  <= '0;
            for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
                queue_data[i] <= '0;
                queue_pc[i]   <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= RUN;
                        fetch_pc <= target_pc;
                        resp_pc  <= target_pc;
                    end
                end
                RUN: begin
                    if (flush) begin
                        // Everything still in flight, less a response landing
                        // right now, belongs to the old stream.
                        wr_ptr      <= '0;
                        rd_ptr      <= '0;
                        count       <= '0;
                        fetch_pc    <= target_pc;
                        resp_pc     <= target_pc;
                        outstanding <= outstanding - OW'(resp_dec);
                        drop_count  <= outstanding - OW'(resp_dec);
                        if (resp) dropped_count <= dropped_count + 32'd1;
                    end else begin
                        outstanding <= outstanding + OW'(accept) - OW'(resp_dec);
                        if (accept) fetch_pc <= fetch_pc + ADDRESS_BITS'(4);
                        if (enq) begin
                            queue_data[wr_ptr] <= fq.mem_data;
                            queue_pc[wr_ptr]   <= resp_pc;
                            wr_ptr             <= wr_ptr + PW'(1);
                            resp_pc            <= resp_pc + ADDRESS_BITS'(4);
                            enqueued_count     <= enqueued_count + 32'd1;
                        end
                        if (drop) begin
                            drop_count    <= drop_count - OW'(1);
                            dropped_count <= dropped_count + 32'd1;
                        end
                        if (pop) rd_ptr <= rd_ptr + PW'(1);
                        count <= count + CW'(enq) - CW'(pop);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        assert (reset || !(enq && !pop && count == CW'(QUEUE_DEPTH)))
            else $error("core %0d: enqueue into full fetch queue", CORE);
        if (report)
            $display("core %0d fetch: state=%s fetch_PC=%h resp_PC=%h count=%0d outstanding=%0d drop=%0d enqueued=%0d dropped=%0d",
                     CORE, state.name(), fetch_pc, resp_pc, count, outstanding,
                     drop_count, enqueued_count, dropped_count);
    end
`endif
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit (QUEUE_DEPTH=4, MAX_OUTSTANDING=2) with
// a one-cycle memory that can be switched to hand-driven responses.
module tb_fetch_queue_unit;
    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [19:0] program_address;
    logic        redirect;
    logic [19:0] redirect_target;
    logic        report;
    logic [2:0]  queue_count;
    logic [19:0] fetch_PC;

    int checks   = 0;
    int failures = 0;
    bit auto_mem = 1'b0;

    fetch_queue_unit_if #(.DATA_WIDTH(32), .ADDRESS_BITS(20)) fq ();

    fetch_queue_unit #(
        .CORE(0), .DATA_WIDTH(32), .ADDRESS_BITS(20),
        .QUEUE_DEPTH(4), .MAX_OUTSTANDING(2)
    ) dut (
        .clock(clock), .reset(reset), .start(start),
        .program_address(program_address), .redirect(redirect),
        .redirect_target(redirect_target), .report(report),
        .queue_count(queue_count), .fetch_PC(fetch_PC), .fq(fq)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: a request accepted at this edge is answered in the next
    // cycle with data 0xC0DE0000 | word address when auto_mem is set.
    task automatic tick();
        logic        acc;
        logic [19:0] addr;
        #1;
        acc  = fq.mem_read && fq.mem_ready;
        addr = fq.mem_address;
        @(posedge clock);
        #1;
        if (auto_mem) begin
            fq.mem_valid = acc;
            fq.mem_data  = 32'hC0DE_0000 | 32'(addr);
        end
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; program_address = '0; redirect = 1'b0;
        redirect_target = '0; report = 1'b0;
        fq.mem_ready = 1'b0; fq.mem_valid = 1'b0; fq.mem_data = '0; fq.inst_ready = 1'b0;
        tick(); tick();

        // Reset state
        check("rst_inst_valid", 64'(fq.inst_valid), 64'd0);
        check("rst_mem_read", 64'(fq.mem_read), 64'd0);
        check("rst_queue_count", 64'(queue_count), 64'd0);
        check("rst_fetch_PC", 64'(fetch_PC), 64'd0);
        check("rst_instruction", 64'(fq.instruction), 64'd0);
        check("rst_inst_PC", 64'(fq.inst_PC), 64'd0);

        // mem_valid is ignored while idle
        reset = 1'b0; tick();
        fq.mem_valid = 1'b1; fq.mem_data = 32'h1234_5678; tick();
        check("idle_queue_count", 64'(queue_count), 64'd0);
        check("idle_inst_valid", 64'(fq.inst_valid), 64'd0);
        fq.mem_valid = 1'b0;

        // Streaming from 0x100, one instruction per cycle
        auto_mem = 1'b1; fq.mem_ready = 1'b1; fq.inst_ready = 1'b1;
        program_address = 20'h100; start = 1'b1; tick();
        start = 1'b0; #1;
        check("boot_fetch_PC", 64'(fetch_PC), 64'h100);
        check("boot_mem_read", 64'(fq.mem_read), 64'd1);
        check("boot_mem_address", 64'(fq.mem_address), 64'h40);
        tick();
        check("stream_mem_address1", 64'(fq.mem_address), 64'h41);
        check("stream_empty", 64'(fq.inst_valid), 64'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("stream_inst_PC", 64'(fq.inst_PC), 64'(32'h100 + 4 * k));
            check("stream_instruction", 64'(fq.instruction), 64'(32'hC0DE_0040 + k));
            check("stream_mem_address", 64'(fq.mem_address), 64'(32'h42 + k));
            check("stream_count", 64'(queue_count), 64'd1);
        end

        // Redirect to 0x300 with decode stalled: fill to exactly 4
        redirect = 1'b1; redirect_target = 20'h300; fq.inst_ready = 1'b0; #1;
        check("redir_no_read", 64'(fq.mem_read), 64'd0);
        tick();
        redirect = 1'b0; #1;
        check("redir_count0", 64'(queue_count), 64'd0);
        check("redir_fetch_PC", 64'(fetch_PC), 64'h300);
        check("redir_mem_address", 64'(fq.mem_address), 64'hC0);
        tick(); tick(); tick(); tick();
        check("fill_count3", 64'(queue_count), 64'd3);
        check("fill_credit_stop", 64'(fq.mem_read), 64'd0);
        tick();
        check("fill_count4", 64'(queue_count), 64'd4);
        check("fill_mem_read0", 64'(fq.mem_read), 64'd0);
        check("fill_head_PC", 64'(fq.inst_PC), 64'h300);
        check("fill_head_data", 64'(fq.instruction), 64'hC0DE_00C0);
        tick(); tick();
        check("full_hold", 64'(queue_count), 64'd4);
        check("full_fetch_PC", 64'(fetch_PC), 64'h310);

        // Full queue: simultaneous enqueue and dequeue across pointer wrap
        auto_mem = 1'b0; fq.inst_ready = 1'b1; fq.mem_valid = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            automatic int pc = 32'h300 + 4 * k;
            fq.mem_data = 32'hD000_0000 | 32'(32'h30C + 4 * k);
            tick();
            check("wrap_count", 64'(queue_count), 64'd4);
            check("wrap_inst_PC", 64'(fq.inst_PC), 64'(pc));
            check("wrap_instruction", 64'(fq.instruction),
                  64'((pc < 32'h310) ? (32'hC0DE_0000 | (pc >> 2)) : (32'hD000_0000 | pc)));
        end
        fq.mem_valid = 1'b0; fq.mem_ready = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            automatic int pc = 32'h328 + 4 * j;
            tick();
            check("drain_count", 64'(queue_count), 64'(4 - j));
            if (j < 4) begin
                check("drain_inst_PC", 64'(fq.inst_PC), 64'(pc));
                check("drain_instruction", 64'(fq.instruction), 64'(32'hD000_0000 | pc));
            end
        end
        check("drain_empty", 64'(fq.inst_valid), 64'd0);

        // Two outstanding, redirect to 0x203 (low bits ignored)
        fq.mem_ready = 1'b1; tick(); tick();
        check("two_out_cap", 64'(fq.mem_read), 64'd0);
        redirect = 1'b1; redirect_target = 20'h203; tick();
        redirect = 1'b0; fq.mem_valid = 1'b1; fq.mem_data = 32'hDEAD_0001; #1;
        check("r2_fetch_PC", 64'(fetch_PC), 64'h200);
        check("r2_mem_read", 64'(fq.mem_read), 64'd0);
        check("r2_count", 64'(queue_count), 64'd0);
        tick();
        check("r2_drop1_count", 64'(queue_count), 64'd0);
        check("r2_mem_address", 64'(fq.mem_address), 64'h80);
        fq.mem_data = 32'hDEAD_0002; tick();
        check("r2_drop2_empty", 64'(fq.inst_valid), 64'd0);
        fq.mem_ready = 1'b0; fq.inst_ready = 1'b0; fq.mem_data = 32'h1111_0080; tick();
        fq.mem_valid = 1'b0;
        check("r2_head_PC", 64'(fq.inst_PC), 64'h200);
        check("r2_head_data", 64'(fq.instruction), 64'h1111_0080);
        check("r2_count1", 64'(queue_count), 64'd1);

        // Redirect coincident with the only outstanding response
        fq.mem_ready = 1'b1; tick();
        fq.mem_ready = 1'b0; redirect = 1'b1; redirect_target = 20'h400;
        fq.mem_valid = 1'b1; fq.mem_data = 32'hBAD0_BAD0; fq.inst_ready = 1'b1; tick();
        redirect = 1'b0; fq.mem_valid = 1'b0; fq.inst_ready = 1'b0; #1;
        check("r1_count0", 64'(queue_count), 64'd0);
        check("r1_fetch_PC", 64'(fetch_PC), 64'h400);
        check("r1_mem_address", 64'(fq.mem_address), 64'h100);
        fq.mem_ready = 1'b1; tick();
        fq.mem_ready = 1'b0; fq.mem_valid = 1'b1; fq.mem_data = 32'h2222_0100; tick();
        fq.mem_valid = 1'b0;
        check("r1_head_PC", 64'(fq.inst_PC), 64'h400);
        check("r1_head_data", 64'(fq.instruction), 64'h2222_0100);
        check("r1_count1", 64'(queue_count), 64'd1);

        // Reset mid-stream with two outstanding
        fq.mem_ready = 1'b1; tick(); tick();
        check("mid_two_out", 64'(fq.mem_read), 64'd0);
        reset = 1'b1; tick();
        check("mid_rst_inst_valid", 64'(fq.inst_valid), 64'd0);
        check("mid_rst_mem_read", 64'(fq.mem_read), 64'd0);
        check("mid_rst_fetch_PC", 64'(fetch_PC), 64'd0);
        check("mid_rst_count", 64'(queue_count), 64'd0);
        reset = 1'b0; fq.mem_valid = 1'b1; fq.mem_data = 32'h5555_5555; tick();
        check("post_rst_idle_read", 64'(fq.mem_read), 64'd0);
        check("post_rst_idle_count", 64'(queue_count), 64'd0);
        fq.mem_valid = 1'b0;
        program_address = 20'h107; start = 1'b1; tick();
        start = 1'b0; #1;
        check("restart_mem_address", 64'(fq.mem_address), 64'h41);

        report = 1'b1; tick(); report = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
Decoupled, parametrised instruction fetch front end with a prefetch queue. It issues sequential word-address read requests to the instruction memory interface, with up to MAX_OUTSTANDING requests in flight. Returned instructions and their PCs are buffered in a QUEUE_DEPTH-entry FIFO, which decode drains through a valid/ready handshake. A redirect port (jump, branch or interrupt, resolved downstream) flushes the queue and discards any stale in-flight responses.

Parameters:
CORE, 0, core id used in report output
DATA_WIDTH, 32, instruction width
ADDRESS_BITS, 20, byte-address width of the PC
QUEUE_DEPTH, 4, FIFO entries; power of two, at least 2
MAX_OUTSTANDING, 2, maximum in-flight memory reads; at least 1

Ports:
clock  in  1  single clock; all state updates on its rising edge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; loads program_address and begins fetching
program_address  in  ADDRESS_BITS  boot PC (byte address)
redirect  in  1  flush and restart fetch at redirect_target
redirect_target  in  ADDRESS_BITS  new PC; bits [1:0] are ignored (treated as 0)
mem_read  out  1  read request
mem_address  out  ADDRESS_BITS  word address, equal to fetch_PC >> 2
mem_ready  in  1  memory accepts the request this cycle
mem_valid  in  1  response valid; responses return in request order
mem_data  in  DATA_WIDTH  response instruction
inst_valid  out  1  queue head is valid
inst_ready  in  1  decode consumes the head
instruction  out  DATA_WIDTH  queue head instruction
inst_PC  out  ADDRESS_BITS  queue head byte PC
queue_count  out  log2(QUEUE_DEPTH)+1  current occupancy
fetch_PC  out  ADDRESS_BITS  next PC to be requested
report  in  1  prints a $display state dump when high

Behaviour:
- States: IDLE and RUN. Reset puts the block in IDLE. start moves IDLE to RUN. start while in RUN acts as a redirect to program_address. The block never leaves RUN except on reset.
- Reset values: every register cleared. mem_read=0, inst_valid=0, queue_count=0, fetch_PC=0, instruction=0, inst_PC=0. In IDLE, mem_read=0 and mem_valid is ignored.
- Request issue (combinational):
  - mem_read = RUN & !redirect & !start & (outstanding < MAX_OUTSTANDING) & (queue_count + outstanding - drop_count < QUEUE_DEPTH).
  - A request is accepted when mem_read & mem_ready. On acceptance, fetch_PC += 4 (wraps modulo 2^ADDRESS_BITS) and outstanding increments.
- Responses:
  - Every mem_valid decrements outstanding.
  - If drop_count > 0, the response is discarded and drop_count decrements.
  - Otherwise {mem_data, resp_PC} is enqueued and resp_PC += 4.
  - The credit check guarantees the queue never overflows. An enqueue into a full queue is an assertion failure.
- Dequeue: inst_valid = (queue_count != 0). The head pops when inst_valid & inst_ready. instruction and inst_PC are the registered head entry, with no added latency.
- Minimum latency: a response received in cycle N is visible at the head in cycle N+1 when the queue was empty.
- Simultaneous enqueue and dequeue: allowed at any occupancy, including full. queue_count is unchanged.
- Redirect (redirect, or start while in RUN), registered at the clock edge:
  - Queue cleared; read and write pointers reset to 0.
  - fetch_PC and resp_PC are loaded with {target[ADDRESS_BITS-1:2], 2'b00}.
  - drop_count <= outstanding - mem_valid.
  - A response arriving in the redirect cycle is discarded.
  - inst_ready in the redirect cycle is ignored.
  - No request is issued in the redirect cycle. Fetching resumes the next cycle.
- Back-to-back redirects: each one recomputes drop_count. The last target wins.
- Reset mid-operation: all state clears, including outstanding and drop_count. The memory interface shares the same reset, so no stale responses are expected after reset.
- Pointer arithmetic:
  - Pointers are log2(QUEUE_DEPTH) bits wide and wrap naturally.
  - queue_count is one bit wider.
  - outstanding and drop_count are log2(MAX_OUTSTANDING)+1 bits wide and never underflow.
- Statistics: 32-bit enqueued_count and dropped_count registers, cleared on reset and printed when report is high.

Test Plan:
- Reset, start with program_address=0x100, mem_ready=1, one-cycle memory, inst_ready=1 -> mem_address sequence 0x40, 0x41, 0x42…; head PCs 0x100, 0x104, 0x108 in order, one per cycle.
- inst_ready=0, QUEUE_DEPTH=4, MAX_OUTSTANDING=2 -> exactly 4 entries enqueued; mem_read falls once queue_count + outstanding reaches 4; queue_count holds at 4, no overflow.
- With 2 reads outstanding, redirect to 0x200 -> both stale responses discarded (dropped_count=2); next head inst_PC=0x200; queue_count goes to 0 the cycle after the redirect.
- Redirect coincident with mem_valid, 1 outstanding -> drop_count=0 and the response is dropped; the next response is enqueued with inst_PC=target.
- Full queue with simultaneous mem_valid and inst_ready -> queue_count stays 4; FIFO order preserved across pointer wrap after 10 further entries.
- Reset asserted mid-stream with 2 outstanding -> the next cycle shows inst_valid=0, mem_read=0, fetch_PC=0, state IDLE until start.
